usb_system_switch_debounce_ctrl: RTL

// - Avalon-MM slave controller for the 18 board slide switches; replaces raw switch sampling.
// - Synchronises and debounces each switch, captures rising edges and raises a maskable IRQ.
// - Software programs the debounce period at run time.
// - Sits between the switch pins and the system interconnect.

---
 rtl/usb_system_switch_debounce_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/usb_system_switch_debounce_ctrl.sv
// ---------------------------------------------------------------------------
// usb_system_switch_debounce_ctrl
//
// Avalon-MM slave for the board slide switches. Each switch is synchronised
// by two flops and then debounced by its own counter. A new level is
// accepted only after it has persisted for a run-time programmable number
// of clk cycles. Accepted rising edges are captured and can raise a maskable,
// level-sensitive interrupt.
//
// Optional feature macro: SWITCH_IRQ_EN
//   defined   - EDGECAP, IRQMASK and irq are implemented.
//   undefined - no edge/mask storage, irq tied low, addresses 2/3 read 0
//               and writes to them are dropped.
//
// Register map (32-bit, zero-extended on read, read latency 1):
//   0 DATA    RO    debounced switch levels
//   1 PERIOD  RW    debounce period in clk cycles (0 behaves as 1)
//   2 IRQMASK RW    per-switch interrupt enable
//   3 EDGECAP R/W1C captured rising edges of the debounced levels
//
// Ports:
//   clk         in   system clock, single domain
//   reset       in   synchronous reset, active-high
//   address     in   register select
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   write data
//   in_port     in   raw asynchronous switch levels
//   readdata    out  registered read data
//   irq         out  interrupt request, active-high level
// ---------------------------------------------------------------------------
module usb_system_switch_debounce_ctrl #(
  parameter int WIDTH      = 18,
  parameter int CNT_W      = 16,
  parameter int PERIOD_RST = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Bus decode
  logic             wr_s;
  logic             wr_period_s;

  // Synchroniser and debounce state
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] deb_q;
  logic [WIDTH-1:0] deb_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] period_d;
  logic [CNT_W-1:0] eff_m1_s;

  // Read path
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;

  // Only the low bits of writedata are stored; the rest are don't-care.
  logic             unused_wdata_s;

  assign unused_wdata_s = ^writedata;

  assign wr_s        = chipselect && !write_n;
  assign wr_period_s = wr_s && (address == 2'd1);

  // Terminal count is eff-1 where eff = max(PERIOD, 1), so PERIOD=0 accepts
  // a new level after a single synced cycle.
  assign eff_m1_s = (period_q == CNT_ZERO) ? CNT_ZERO : (period_q - CNT_ONE);

  // Period register next state
  always_comb begin
    period_d = period_q;
    if (wr_period_s) begin
      period_d = writedata[CNT_W-1:0];
    end else begin
      period_d = period_q;
    end
  end

  // Per-bit debounce counters and accepted levels
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = CNT_ZERO;
      if (wr_period_s) begin
        // A period change restarts every pending count so a shrunk period
        // can never leave a counter beyond its new terminal value.
        cnt_d[i] = CNT_ZERO;
      end else if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] == eff_m1_s) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = CNT_ZERO;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

`ifdef SWITCH_IRQ_EN
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] edge_d;
  logic             irq_q;
  logic             irq_d;
  logic             wr_mask_s;
  logic             wr_edge_s;

  assign wr_mask_s = wr_s && (address == 2'd2);
  assign wr_edge_s = wr_s && (address == 2'd3);

  // Mask, edge capture and interrupt next state
  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    if (wr_mask_s) begin
      mask_d = writedata[WIDTH-1:0];
    end else begin
      mask_d = mask_q;
    end
    // Clear first, then OR in new rises so a simultaneous set wins.
    if (wr_edge_s) begin
      edge_d = (edge_q & ~writedata[WIDTH-1:0]) | (deb_d & ~deb_q);
    end else begin
      edge_d = edge_q | (deb_d & ~deb_q);
    end
    irq_d = |(edge_q & mask_q);
  end

  // Interrupt state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= {WIDTH{1'b0}};
      edge_q <= {WIDTH{1'b0}};
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      edge_q <= edge_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Read mux, sampled every cycle regardless of chipselect
  always_comb begin
    readdata_d = 32'd0;
    case (address)
      2'd0:    readdata_d = {{(32-WIDTH){1'b0}}, deb_q};
      2'd1:    readdata_d = {{(32-CNT_W){1'b0}}, period_q};
`ifdef SWITCH_IRQ_EN
      2'd2:    readdata_d = {{(32-WIDTH){1'b0}}, mask_q};
      2'd3:    readdata_d = {{(32-WIDTH){1'b0}}, edge_q};
`endif
      default: readdata_d = 32'd0;
    endcase
  end

  // Synchroniser, debounce and register state
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= {WIDTH{1'b0}};
      sync2_q    <= {WIDTH{1'b0}};
      deb_q      <= {WIDTH{1'b0}};
      period_q   <= CNT_W'(PERIOD_RST);
      readdata_q <= 32'd0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      period_q   <= period_d;
      readdata_q <= readdata_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign readdata = readdata_q;

endmodule
